// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for dm_access_unit.
//   - Bit positions inside the 9-bit one-hot ExtType vector
//     {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}; lb is bit 8, swr is bit 0.
//   - State type for the data-memory stall controller.
package dm_access_unit_pkg;

  localparam int unsigned EXT_W   = 9;
  localparam int unsigned EXT_LB  = 8;
  localparam int unsigned EXT_LBU = 7;
  localparam int unsigned EXT_LH  = 6;
  localparam int unsigned EXT_LHU = 5;
  localparam int unsigned EXT_LW  = 4;
  localparam int unsigned EXT_LWL = 3;
  localparam int unsigned EXT_LWR = 2;
  localparam int unsigned EXT_SWL = 1;
  localparam int unsigned EXT_SWR = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    UC_WAIT = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_access_unit_if.sv
// Data-memory handshake between the E/M pipeline stage and the memory side.
//   is_load, is_store  : E-stage instruction is a load / store
//   uncached           : access targets the uncached SRAM port
//   hit                : cache hit for the current cached access
//   data_sram_data_ok  : uncached transfer complete this cycle
//   read, write        : request strobes produced by dm_access_unit
//   dm_stall           : pipeline hold at the E/M boundary
// slave  : used by dm_access_unit (consumes status, drives strobes/stall)
// master : used by the surrounding pipeline/memory model
interface dm_access_unit_if;

  logic is_load;
  logic is_store;
  logic uncached;
  logic hit;
  logic data_sram_data_ok;
  logic read;
  logic write;
  logic dm_stall;

  modport slave (
    input  is_load, is_store, uncached, hit, data_sram_data_ok,
    output read, write, dm_stall
  );

  modport master (
    output is_load, is_store, uncached, hit, data_sram_data_ok,
    input  read, write, dm_stall
  );

endinterface

// File: rtl/dm_access_unit_load_ext_unit.sv
// load_ext_unit: combinational load-data extraction/extension and per-byte
// register write enables for the stage after memory.
//   RawMemData            in  32  word captured by the M stage
//   Offset                in   2  byte address [1:0]
//   ExtType               in   9  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}
//   M_WriteRegEnable      in   1  M-stage register write enable
//   ExtMemData            out 32  extended load data
//   M_WriteRegEnableExted out  4  per-byte write enable, bit i = byte i
module load_ext_unit
  import dm_access_unit_pkg::*;
(
  input  logic [31:0]      RawMemData,
  input  logic [1:0]       Offset,
  input  logic [EXT_W-1:0] ExtType,
  input  logic             M_WriteRegEnable,
  output logic [31:0]      ExtMemData,
  output logic [3:0]       M_WriteRegEnableExted
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lwr_shamt;
  logic [4:0]  lwl_shamt;

  // 3 - Offset equals ~Offset for a 2-bit value.
  assign lwr_shamt = {Offset, 3'b000};
  assign lwl_shamt = {~Offset, 3'b000};

  assign byte_sel = RawMemData[{Offset, 3'b000} +: 8];
  assign half_sel = Offset[1] ? RawMemData[31:16] : RawMemData[15:0];

  always_comb begin
    ExtMemData = RawMemData;
    if (ExtType[EXT_LB]) begin
      ExtMemData = {{24{byte_sel[7]}}, byte_sel};
    end else if (ExtType[EXT_LBU]) begin
      ExtMemData = {24'h000000, byte_sel};
    end else if (ExtType[EXT_LH]) begin
      ExtMemData = {{16{half_sel[15]}}, half_sel};
    end else if (ExtType[EXT_LHU]) begin
      ExtMemData = {16'h0000, half_sel};
    end else if (ExtType[EXT_LW]) begin
      ExtMemData = RawMemData;
    end else if (ExtType[EXT_LWL]) begin
      ExtMemData = RawMemData << lwl_shamt;
    end else if (ExtType[EXT_LWR]) begin
      ExtMemData = RawMemData >> lwr_shamt;
    end
  end

  // lwl merges into the upper bytes, lwr into the lower bytes.
  always_comb begin
    M_WriteRegEnableExted = '0;
    if (M_WriteRegEnable) begin
      if (ExtType[EXT_LWL]) begin
        M_WriteRegEnableExted = 4'b1111 << ~Offset;
      end else if (ExtType[EXT_LWR]) begin
        M_WriteRegEnableExted = 4'b1111 >> Offset;
      end else begin
        M_WriteRegEnableExted = '1;
      end
    end
  end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: memory-stage helper. Generates data-memory request strobes
// and the stage stall for cached/uncached accesses, and extends load data.
//   Clk                   in   1  clock, rising edge
//   Clr                   in   1  synchronous active-high reset / flush
//   bus                   slave  handshake (see dm_access_unit_if)
//   RawMemData            in  32  word captured by the M stage
//   Offset                in   2  byte address [1:0]
//   ExtType               in   9  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}
//   M_WriteRegEnable      in   1  M-stage register write enable
//   ExtMemData            out 32  extended load data
//   M_WriteRegEnableExted out  4  per-byte register write enable
module dm_access_unit
  import dm_access_unit_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Clr,
  dm_access_unit_if.slave        bus,
  input  logic [31:0]            RawMemData,
  input  logic [1:0]             Offset,
  input  logic [EXT_W-1:0]       ExtType,
  input  logic                   M_WriteRegEnable,
  output logic [31:0]            ExtMemData,
  output logic [3:0]             M_WriteRegEnableExted
);

  dm_state_e state;
  dm_state_e next_state;
  logic      acc;

  assign acc = bus.is_load | bus.is_store;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (acc && bus.uncached) next_state = UC_WAIT;
      UC_WAIT: if (bus.data_sram_data_ok) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Uncached requests strobe once on entry; cached requests hold until hit.
  always_comb begin
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.dm_stall = 1'b0;
    if (!Clr) begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            bus.read     = bus.is_load;
            bus.write    = bus.is_store;
            bus.dm_stall = bus.uncached ? 1'b1 : ~bus.hit;
          end
        end
        UC_WAIT: begin
          bus.dm_stall = ~bus.data_sram_data_ok;
        end
        default: ;
      endcase
    end
  end

  load_ext_unit u_load_ext (
    .RawMemData            (RawMemData),
    .Offset                (Offset),
    .ExtType               (ExtType),
    .M_WriteRegEnable      (M_WriteRegEnable),
    .ExtMemData            (ExtMemData),
    .M_WriteRegEnableExted (M_WriteRegEnableExted)
  );

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;
  import dm_access_unit_pkg::*;

  logic        Clk;
  logic        Clr;
  logic [31:0] RawMemData;
  logic [1:0]  Offset;
  logic [8:0]  ExtType;
  logic        M_WriteRegEnable;
  logic [31:0] ExtMemData;
  logic [3:0]  M_WriteRegEnableExted;

  dm_access_unit_if bus ();

  dm_access_unit dut (
    .Clk                   (Clk),
    .Clr                   (Clr),
    .bus                   (bus.slave),
    .RawMemData            (RawMemData),
    .Offset                (Offset),
    .ExtType               (ExtType),
    .M_WriteRegEnable      (M_WriteRegEnable),
    .ExtMemData            (ExtMemData),
    .M_WriteRegEnableExted (M_WriteRegEnableExted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an uncached transfer is outstanding from the edge after its
  // request until the edge on which data_ok is seen; flush abandons it.
  logic uc_outstanding = 1'b0;
  always @(posedge Clk) begin
    if (Clr) uc_outstanding <= 1'b0;
    else if (uc_outstanding) begin
      if (bus.data_sram_data_ok) uc_outstanding <= 1'b0;
    end else if ((bus.is_load || bus.is_store) && bus.uncached) uc_outstanding <= 1'b1;
  end

  function automatic logic [31:0] model_data(input logic [31:0] raw, input logic [8:0] et,
                                             input int unsigned off);
    logic [31:0] b, h;
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * (off / 2))) & 32'hFFFF;
    if (et == 9'b100000000) return (b >= 128) ? b + 32'hFFFFFF00 : b;
    if (et == 9'b010000000) return b;
    if (et == 9'b001000000) return (h >= 32768) ? h + 32'hFFFF0000 : h;
    if (et == 9'b000100000) return h;
    if (et == 9'b000001000) return raw << (8 * (3 - off));
    if (et == 9'b000000100) return raw >> (8 * off);
    return raw;
  endfunction

  function automatic logic [3:0] model_we(input logic [8:0] et, input int unsigned off,
                                          input logic wre);
    logic [3:0] lwl_tbl [4];
    logic [3:0] lwr_tbl [4];
    lwl_tbl = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    lwr_tbl = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    if (!wre) return 4'b0000;
    if (et == 9'b000001000) return lwl_tbl[off];
    if (et == 9'b000000100) return lwr_tbl[off];
    return 4'b1111;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (cmp_en) begin
      logic er, ew, es;
      er = 1'b0; ew = 1'b0; es = 1'b0;
      if (!Clr) begin
        if (uc_outstanding) begin
          es = !bus.data_sram_data_ok;
        end else if (bus.is_load || bus.is_store) begin
          er = bus.is_load;
          ew = bus.is_store;
          es = bus.uncached ? 1'b1 : !bus.hit;
        end
      end
      chk("model_read", {31'b0, bus.read}, {31'b0, er});
      chk("model_write", {31'b0, bus.write}, {31'b0, ew});
      chk("model_stall", {31'b0, bus.dm_stall}, {31'b0, es});
      chk("model_data", ExtMemData, model_data(RawMemData, ExtType, 32'(Offset)));
      chk("model_we", {28'b0, M_WriteRegEnableExted},
          {28'b0, model_we(ExtType, 32'(Offset), M_WriteRegEnable)});
    end
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_bus(input logic l, input logic s, input logic u, input logic h,
                         input logic ok);
    bus.is_load = l; bus.is_store = s; bus.uncached = u; bus.hit = h;
    bus.data_sram_data_ok = ok;
  endtask

  task automatic chk_rws(input string name, input logic r, input logic w, input logic s);
    @(negedge Clk);
    chk({name, "_read"}, {31'b0, bus.read}, {31'b0, r});
    chk({name, "_write"}, {31'b0, bus.write}, {31'b0, w});
    chk({name, "_stall"}, {31'b0, bus.dm_stall}, {31'b0, s});
  endtask

  task automatic chk_ext(input string name, input logic [31:0] raw, input logic [8:0] et,
                         input logic [1:0] off, input logic wre,
                         input logic [31:0] exp_d, input logic [3:0] exp_we);
    RawMemData = raw; ExtType = et; Offset = off; M_WriteRegEnable = wre;
    @(negedge Clk);
    chk({name, "_data"}, ExtMemData, exp_d);
    chk({name, "_we"}, {28'b0, M_WriteRegEnableExted}, {28'b0, exp_we});
    next_cycle();
  endtask

  initial begin
    logic [31:0] raws [3];
    raws = '{32'h80FF7F01, 32'h11223344, 32'h7F8001FE};
    Clr = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RawMemData = '0; Offset = '0; ExtType = '0; M_WriteRegEnable = 1'b0;
    next_cycle();
    cmp_en = 1'b1;
    // Reset holds outputs low even with a request present.
    set_bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_rws("reset", 1'b0, 1'b0, 1'b0);
    next_cycle();
    Clr = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_rws("idle", 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Uncached load, data_ok in the third cycle.
    set_bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_rws("ucl_c1", 1'b1, 1'b0, 1'b1);
    next_cycle();
    chk_rws("ucl_c2", 1'b0, 1'b0, 1'b1);
    next_cycle();
    bus.data_sram_data_ok = 1'b1;
    chk_rws("ucl_c3", 1'b0, 1'b0, 1'b0);
    next_cycle();
    // Back in IDLE: a fresh uncached load issues again.
    bus.data_sram_data_ok = 1'b0;
    chk_rws("ucl_again", 1'b1, 1'b0, 1'b1);
    next_cycle();
    bus.data_sram_data_ok = 1'b1;
    chk_rws("ucl_min", 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Cached store, two miss cycles then hit.
    set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_rws("cst_c1", 1'b0, 1'b1, 1'b1);
    next_cycle();
    chk_rws("cst_c2", 1'b0, 1'b1, 1'b1);
    next_cycle();
    bus.hit = 1'b1;
    chk_rws("cst_c3", 1'b0, 1'b1, 1'b0);
    next_cycle();
    // Cached load hit: no stall.
    set_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rws("cld_hit", 1'b1, 1'b0, 1'b0);
    next_cycle();

    // data_ok while idle is ignored.
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_rws("ok_idle", 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_bus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_rws("ucs_c1", 1'b0, 1'b1, 1'b1);
    next_cycle();
    bus.data_sram_data_ok = 1'b1;
    chk_rws("ucs_c2", 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Clear in UC_WAIT, with data_ok also high.
    set_bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_rws("clr_c1", 1'b1, 1'b0, 1'b1);
    next_cycle();
    Clr = 1'b1;
    bus.data_sram_data_ok = 1'b1;
    chk_rws("clr_c2", 1'b0, 1'b0, 1'b0);
    next_cycle();
    Clr = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    chk_rws("clr_c3", 1'b1, 1'b0, 1'b1);
    next_cycle();
    Clr = 1'b1;
    chk_rws("clr_c4", 1'b0, 1'b0, 1'b0);
    next_cycle();
    Clr = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Hand-computed extension vectors.
    chk_ext("lb2",   32'h80FF7F01, 9'b100000000, 2'd2, 1'b1, 32'hFFFFFFFF, 4'b1111);
    chk_ext("lbu3",  32'h80FF7F01, 9'b010000000, 2'd3, 1'b1, 32'h00000080, 4'b1111);
    chk_ext("lb0",   32'h80FF7F01, 9'b100000000, 2'd0, 1'b1, 32'h00000001, 4'b1111);
    chk_ext("lh2",   32'h80FF7F01, 9'b001000000, 2'd2, 1'b1, 32'hFFFF80FF, 4'b1111);
    chk_ext("lh3",   32'h80FF7F01, 9'b001000000, 2'd3, 1'b1, 32'hFFFF80FF, 4'b1111);
    chk_ext("lhu0",  32'h80FF7F01, 9'b000100000, 2'd0, 1'b1, 32'h00007F01, 4'b1111);
    chk_ext("lhu1",  32'h80FF7F01, 9'b000100000, 2'd1, 1'b1, 32'h00007F01, 4'b1111);
    chk_ext("lwl1",  32'h11223344, 9'b000001000, 2'd1, 1'b1, 32'h33440000, 4'b1100);
    chk_ext("lwl0",  32'h11223344, 9'b000001000, 2'd0, 1'b1, 32'h44000000, 4'b1000);
    chk_ext("lwl3",  32'h11223344, 9'b000001000, 2'd3, 1'b1, 32'h11223344, 4'b1111);
    chk_ext("lwr2",  32'h11223344, 9'b000000100, 2'd2, 1'b1, 32'h00001122, 4'b0011);
    chk_ext("lwr3",  32'h11223344, 9'b000000100, 2'd3, 1'b1, 32'h00000011, 4'b0001);
    chk_ext("lw_off",32'h11223344, 9'b000010000, 2'd1, 1'b0, 32'h11223344, 4'b0000);
    chk_ext("swl",   32'h11223344, 9'b000000010, 2'd2, 1'b1, 32'h11223344, 4'b1111);
    chk_ext("none",  32'h80FF7F01, 9'b000000000, 2'd1, 1'b1, 32'h80FF7F01, 4'b1111);

    // Sweep every type/offset/enable combination against the model.
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 10; t++) begin
        for (int o = 0; o < 4; o++) begin
          for (int w = 0; w < 2; w++) begin
            RawMemData = raws[r];
            ExtType = (t < 9) ? (9'd1 << t) : 9'd0;
            Offset = 2'(o);
            M_WriteRegEnable = w[0];
            next_cycle();
          end
        end
      end
    end

    @(negedge Clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
